cpu: RTL and testbench
======================

Name: cpu

Overview:
- 32-bit MIPS-subset processor with a classic 5-stage pipeline: IF, ID, EX, MEM, WB.
- Connects to an external combinational instruction/data memory through separate instruction and data ports.
- Includes a 32x32 register file, forwarding, load-use stall and branch/jump flush logic.
- Top-level block of the processor; the bench observes architectural state through the register file.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- instructionAddress  output  32  byte address of the instruction being fetched (the PC).
- instruction  input  32  instruction word returned combinationally by memory for instructionAddress.
- dataAddress  output  32  byte address for a MEM-stage load or store (the ALU result).
- dataIn  output  32  store data driven to memory.
- MemRead  output  1  high during MEM stage of lw.
- MemWrite  output  1  high during MEM stage of sw, for exactly one cycle.
- dataOut  input  32  load data returned combinationally by memory.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC; all pipeline registers cleared to bubble (no regwrite, no mem access).
  - All 32 registers =0.
  - Outputs: instructionAddress=RESET_PC, dataAddress=0, dataIn=0, MemRead=0, MemWrite=0.
  - Reset asserted mid-operation abandons all in-flight instructions.
- ISA:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, nop (all-zero word).
  - I-type: addi 0x08 (sign-extended imm), lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - J-type: j 0x02.
  - Unknown opcodes execute as nop.
- Arithmetic: 32-bit two's-complement; overflow ignored, wraps. slt is a signed compare giving 1 or 0.
- Register $0 reads 0 always; writes to it are discarded, and it is never a forwarding source.
- PC advances +4 per fetch when not stalled.
- Register file:
  - Two combinational read ports, one write port written in WB on the rising edge.
  - Same-cycle write/read of the same register returns the new value (internal bypass).
  - Sub-module instance named regFile, holding array regFile[0:31], visible hierarchically for verification.
- Forwarding into EX operands, priority EX/MEM over MEM/WB, from any producer with regwrite and dest≠0.
  - sw store data is forwarded the same way.
- Load-use hazard:
  - When lw in EX has dest equal to rs or rt of the instruction in ID, stall one cycle.
  - During the stall, hold PC and IF/ID and insert a bubble into ID/EX.
- Branches (beq/bne):
  - Resolved in EX; target = PC+4 + (sign-extended imm << 2).
  - Taken: flush IF/ID and ID/EX (2 bubbles).
  - No delay slot; not-taken predicted.
- Jumps (j):
  - Resolved in ID; target = {PC+4[31:28], imm26, 2'b00}.
  - Flush IF/ID (1 bubble).
- Simultaneous events:
  - Taken branch in EX overrides a stall or jump from ID in the same cycle.
- Latency and throughput:
  - Writeback occurs 4 cycles after fetch.
  - Steady-state CPI 1 absent hazards.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants and funct constants.
  - ALU-op enum (ADD, SUB, AND, OR, SLT).
  - Pipeline-register struct typedefs (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One natural sub-module: cpu_regfile (instance name regFile).
- ALU, control decode, forwarding and hazard logic stay inline in cpu.

Test Plan:
- Reset release: hold reset=0 for 5 ns then drive 1 → first fetch at instructionAddress 0; all registers 0; MemRead/MemWrite 0.
- Back-to-back dependence: addi $1,$0,5; addi $2,$1,3; add $3,$1,$2 → $1=5, $2=8, $3=13, with no stall cycles.
- Memory and load-use: sw $3,0($0); lw $4,0($0); add $5,$4,$4.
  - MemWrite pulses once with dataAddress 0, dataIn 13.
  - One stall cycle; $4=13, $5=26.
- Branch loop: $19 counts 0..9 via addi/bne while $8 accumulates +3 from 1 → terminate with $8=28, $19=9.
  - Instructions after a taken bne are squashed.
- Jump and $0: j skips addi $6,$0,99; addi $0,$0,7 → $6 unchanged (0), $0 stays 0.
- Mid-run reset: assert reset during the loop → PC returns to 0, all registers 0, and the program reruns to the same final values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS-subset pipeline: encodings, ALU ops and
// pipeline register layouts.
package cpu_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        bne;
    logic        alusrc;
    alu_op_e     aluop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } id_ex_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } mem_wb_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to zero.
module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regFile [0:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regFile[waddr] <= wdata;
    end
  end

  // A write landing this cycle is visible to ID immediately.
  always_comb begin
    if (raddr1 == 5'd0)                 rdata1 = '0;
    else if (we && waddr == raddr1)     rdata1 = wdata;
    else                                rdata1 = regFile[raddr1];
    if (raddr2 == 5'd0)                 rdata2 = '0;
    else if (we && waddr == raddr2)     rdata2 = wdata;
    else                                rdata2 = regFile[raddr2];
  end

endmodule

// File: rtl/cpu.sv
// 5-stage MIPS-subset pipeline with EX forwarding, load-use stall, branches resolved in EX
// and jumps resolved in ID.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instructionAddress,
  input  logic [31:0] instruction,
  output logic [31:0] dataAddress,
  output logic [31:0] dataIn,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] dataOut
);

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rdata1, rdata2, jump_target;
  logic        jump, stall;
  id_ex_t      dec;

  logic [31:0] fwd_a, fwd_b, alu_b, alu_res, br_target;
  logic        taken;

  cpu_regfile regFile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs),
    .raddr2 (rt),
    .we     (mem_wb_q.regwrite),
    .waddr  (mem_wb_q.dest),
    .wdata  (mem_wb_q.wdata),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // ID: decode
  always_comb begin
    opcode      = if_id_q.instr[31:26];
    rs          = if_id_q.instr[25:21];
    rt          = if_id_q.instr[20:16];
    rd          = if_id_q.instr[15:11];
    funct       = if_id_q.instr[5:0];
    jump        = (opcode == OpJ);
    jump_target = {if_id_q.pc4[31:28], if_id_q.instr[25:0], 2'b00};
    dec         = '0;
    dec.aluop   = AluAdd;
    dec.rs      = rs;
    dec.rt      = rt;
    dec.rdata1  = rdata1;
    dec.rdata2  = rdata2;
    dec.imm     = sign_ext16(if_id_q.instr[15:0]);
    dec.pc4     = if_id_q.pc4;
    case (opcode)
      OpRtype: begin
        dec.dest     = rd;
        dec.regwrite = 1'b1;
        case (funct)
          FnAdd:   dec.aluop = AluAdd;
          FnSub:   dec.aluop = AluSub;
          FnAnd:   dec.aluop = AluAnd;
          FnOr:    dec.aluop = AluOr;
          FnSlt:   dec.aluop = AluSlt;
          default: dec.regwrite = 1'b0;
        endcase
      end
      OpAddi: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.dest     = rt;
      end
      OpLw: begin
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.alusrc   = 1'b1;
        dec.dest     = rt;
      end
      OpSw: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OpBeq: dec.branch = 1'b1;
      OpBne: begin
        dec.branch = 1'b1;
        dec.bne    = 1'b1;
      end
      default: ;
    endcase
    stall = id_ex_q.memread && (id_ex_q.dest == rs || id_ex_q.dest == rt);
  end

  // EX: forwarding (EX/MEM wins over MEM/WB), ALU and branch resolution
  always_comb begin
    fwd_a = id_ex_q.rdata1;
    if (ex_mem_q.regwrite && ex_mem_q.dest != 5'd0 && ex_mem_q.dest == id_ex_q.rs)
      fwd_a = ex_mem_q.alu_result;
    else if (mem_wb_q.regwrite && mem_wb_q.dest != 5'd0 && mem_wb_q.dest == id_ex_q.rs)
      fwd_a = mem_wb_q.wdata;
    fwd_b = id_ex_q.rdata2;
    if (ex_mem_q.regwrite && ex_mem_q.dest != 5'd0 && ex_mem_q.dest == id_ex_q.rt)
      fwd_b = ex_mem_q.alu_result;
    else if (mem_wb_q.regwrite && mem_wb_q.dest != 5'd0 && mem_wb_q.dest == id_ex_q.rt)
      fwd_b = mem_wb_q.wdata;
    alu_b = id_ex_q.alusrc ? id_ex_q.imm : fwd_b;
    case (id_ex_q.aluop)
      AluAdd:  alu_res = fwd_a + alu_b;
      AluSub:  alu_res = fwd_a - alu_b;
      AluAnd:  alu_res = fwd_a & alu_b;
      AluOr:   alu_res = fwd_a | alu_b;
      AluSlt:  alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_res = fwd_a + alu_b;
    endcase
    taken     = id_ex_q.branch && ((fwd_a == fwd_b) != id_ex_q.bne);
    br_target = id_ex_q.pc4 + {id_ex_q.imm[29:0], 2'b00};

    ex_mem_d.regwrite   = id_ex_q.regwrite;
    ex_mem_d.memread    = id_ex_q.memread;
    ex_mem_d.memwrite   = id_ex_q.memwrite;
    ex_mem_d.dest       = id_ex_q.dest;
    ex_mem_d.alu_result = alu_res;
    ex_mem_d.store_data = fwd_b;
  end

  // MEM: load data is folded into the writeback value here
  always_comb begin
    mem_wb_d.regwrite = ex_mem_q.regwrite;
    mem_wb_d.dest     = ex_mem_q.dest;
    mem_wb_d.wdata    = ex_mem_q.memread ? dataOut : ex_mem_q.alu_result;
  end

  // Front-end steering: a taken branch beats a stall, which beats a jump.
  always_comb begin
    pc_d          = pc_q + 32'd4;
    if_id_d.pc4   = pc_q + 32'd4;
    if_id_d.instr = instruction;
    id_ex_d       = dec;
    if (taken) begin
      pc_d    = br_target;
      if_id_d = '0;
      id_ex_d = '0;
    end else if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end else if (jump) begin
      pc_d    = jump_target;
      if_id_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign instructionAddress = pc_q;
  assign dataAddress        = ex_mem_q.alu_result;
  assign dataIn             = ex_mem_q.store_data;
  assign MemRead            = ex_mem_q.memread;
  assign MemWrite           = ex_mem_q.memwrite;

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed programs plus random straight-line/forward-branch programs, checked
// against an instruction-level interpreter.
module tb_cpu;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instructionAddress, instruction, dataAddress, dataIn, dataOut;
  logic        MemRead, MemWrite;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:63];

  int n_checks = 0;
  int n_errors = 0;
  int wr_count, rd_count, stall_count;
  logic [31:0] wr_addr, wr_data, rd_addr;

  logic [31:0] iss_r [0:31];
  logic [31:0] iss_m [0:63];
  int          iss_stores, iss_loads;
  logic [31:0] halt_pc;

  always #5 clk = ~clk;

  assign instruction = imem[instructionAddress[9:2]];
  assign dataOut     = dmem[dataAddress[7:2]];

  always @(posedge clk) if (MemWrite) dmem[dataAddress[7:2]] <= dataIn;

  cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .instructionAddress (instructionAddress),
    .instruction        (instruction),
    .dataAddress        (dataAddress),
    .dataIn             (dataIn),
    .MemRead            (MemRead),
    .MemWrite           (MemWrite),
    .dataOut            (dataOut)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int fn, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rt, input int rs, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(input int idx);
    return {6'h02, 26'(idx)};
  endfunction

  // Architectural interpreter: one instruction per step, no pipeline.
  task automatic run_iss();
    logic [31:0] pc, npc, w, a, b, imm, ea;
    logic [5:0]  op;
    for (int i = 0; i < 32; i++) iss_r[i] = '0;
    for (int i = 0; i < 64; i++) iss_m[i] = dmem[i];
    iss_stores = 0;
    iss_loads  = 0;
    halt_pc    = 32'hFFFF_FFFF;
    pc         = 32'h0;
    for (int s = 0; s < 10000; s++) begin
      w   = imem[pc[9:2]];
      op  = w[31:26];
      a   = iss_r[w[25:21]];
      b   = iss_r[w[20:16]];
      imm = {{16{w[15]}}, w[15:0]};
      ea  = a + imm;
      npc = pc + 4;
      if (op == 6'h02 && {npc[31:28], w[25:0], 2'b00} == pc) begin
        halt_pc = pc;
        break;
      end
      case (op)
        6'h00: case (w[5:0])
          6'h20: iss_r[w[15:11]] = a + b;
          6'h22: iss_r[w[15:11]] = a - b;
          6'h24: iss_r[w[15:11]] = a & b;
          6'h25: iss_r[w[15:11]] = a | b;
          6'h2A: iss_r[w[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h08: iss_r[w[20:16]] = ea;
        6'h23: begin iss_r[w[20:16]] = iss_m[ea[7:2]]; iss_loads++; end
        6'h2B: begin iss_m[ea[7:2]] = b; iss_stores++; end
        6'h04: if (a == b) npc = npc + (imm << 2);
        6'h05: if (a != b) npc = npc + (imm << 2);
        6'h02: npc = {npc[31:28], w[25:0], 2'b00};
        default: ;
      endcase
      iss_r[0] = '0;
      pc = npc;
    end
  endtask

  task automatic clear_mon();
    wr_count = 0; rd_count = 0; stall_count = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic sample();
    if (MemWrite) begin wr_count++; wr_addr = dataAddress; wr_data = dataIn; end
    if (MemRead)  begin rd_count++; rd_addr = dataAddress; end
  endtask

  // Held fetch address on consecutive cycles means a stall cycle.
  task automatic run_until_halt(input int max_cycles, input int drain);
    logic [31:0] prev = '0;
    bit first = 1'b1;
    bit reached = 1'b0;
    for (int c = 0; c < max_cycles && !reached; c++) begin
      @(negedge clk);
      sample();
      if (!first && instructionAddress == prev) stall_count++;
      first = 1'b0;
      prev  = instructionAddress;
      if (instructionAddress == halt_pc) reached = 1'b1;
    end
    check_eq("halt_reached", 32'(reached), 32'd1);
    repeat (drain) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic compare_state(input string tag);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s_r%0d", tag, i), dut.regFile.regFile[i], iss_r[i]);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("%s_m%0d", tag, i), dmem[i], iss_m[i]);
    check_eq({tag, "_stores"}, 32'(wr_count), 32'(iss_stores));
    check_eq({tag, "_loads"}, 32'(rd_count), 32'(iss_loads));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pc"}, instructionAddress, 32'h0);
    check_eq({tag, "_daddr"}, dataAddress, 32'h0);
    check_eq({tag, "_din"}, dataIn, 32'h0);
    check_eq({tag, "_memread"}, 32'(MemRead), 32'd0);
    check_eq({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s_r%0d", tag, i), dut.regFile.regFile[i], 32'h0);
  endtask

  task automatic check_directed(input string tag);
    check_eq({tag, "_r1"}, dut.regFile.regFile[1], 32'd5);
    check_eq({tag, "_r2"}, dut.regFile.regFile[2], 32'd8);
    check_eq({tag, "_r3"}, dut.regFile.regFile[3], 32'd13);
    check_eq({tag, "_r4"}, dut.regFile.regFile[4], 32'd13);
    check_eq({tag, "_r5"}, dut.regFile.regFile[5], 32'd26);
    check_eq({tag, "_r8"}, dut.regFile.regFile[8], 32'd28);
    check_eq({tag, "_r19"}, dut.regFile.regFile[19], 32'd9);
    check_eq({tag, "_r9_squash"}, dut.regFile.regFile[9], 32'd1);
    check_eq({tag, "_r10_squash"}, dut.regFile.regFile[10], 32'd1);
    check_eq({tag, "_r6_jump"}, dut.regFile.regFile[6], 32'd0);
    check_eq({tag, "_r0"}, dut.regFile.regFile[0], 32'd0);
    check_eq({tag, "_sw_pulses"}, 32'(wr_count), 32'd1);
    check_eq({tag, "_sw_addr"}, wr_addr, 32'd0);
    check_eq({tag, "_sw_data"}, wr_data, 32'd13);
    check_eq({tag, "_lw_addr"}, rd_addr, 32'd0);
    check_eq({tag, "_stalls"}, 32'(stall_count), 32'd1);
    compare_state(tag);
  endtask

  task automatic load_directed();
    for (int i = 0; i < 256; i++) imem[i] = '0;
    imem[0]  = i_ins(8, 1, 0, 5);
    imem[1]  = i_ins(8, 2, 1, 3);
    imem[2]  = r_ins(32'h20, 3, 1, 2);
    imem[3]  = i_ins(32'h2B, 3, 0, 0);
    imem[4]  = i_ins(32'h23, 4, 0, 0);
    imem[5]  = r_ins(32'h20, 5, 4, 4);
    imem[6]  = i_ins(8, 8, 0, 1);
    imem[7]  = i_ins(8, 19, 0, 0);
    imem[8]  = i_ins(8, 20, 0, 9);
    imem[9]  = i_ins(8, 8, 8, 3);
    imem[10] = i_ins(8, 19, 19, 1);
    imem[11] = i_ins(5, 20, 19, -3);
    imem[12] = i_ins(8, 9, 9, 1);
    imem[13] = i_ins(8, 10, 10, 1);
    imem[14] = j_ins(16);
    imem[15] = i_ins(8, 6, 0, 99);
    imem[16] = i_ins(8, 0, 0, 7);
    imem[17] = j_ins(17);
  endtask

  task automatic gen_program(input int n);
    int kind, off_max, off;
    for (int i = 0; i < 256; i++) imem[i] = '0;
    for (int i = 0; i < n; i++) begin
      kind    = $urandom_range(0, 11);
      off_max = (n - 1 - i) < 3 ? (n - 1 - i) : 3;
      off     = $urandom_range(0, off_max);
      case (kind)
        0: imem[i] = r_ins(32'h20, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        1: imem[i] = r_ins(32'h22, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        2: imem[i] = r_ins(32'h24, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        3: imem[i] = r_ins(32'h25, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        4: imem[i] = r_ins(32'h2A, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        5, 6: imem[i] = i_ins(8, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
        7: imem[i] = i_ins(32'h23, $urandom_range(0, 7), 0, 4 * $urandom_range(0, 15));
        8: imem[i] = i_ins(32'h2B, $urandom_range(0, 7), 0, 4 * $urandom_range(0, 15));
        9: imem[i] = i_ins($urandom_range(4, 5), $urandom_range(0, 7), $urandom_range(0, 7), off);
        10: imem[i] = j_ins(i + 1 + off);
        default: imem[i] = ($urandom_range(0, 1) == 1) ? {6'h3F, 26'($urandom)} : 32'h0;
      endcase
    end
    imem[n] = j_ins(n);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    load_directed();
    #1 reset = 1'b0;
    #5;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;
    #1 check_eq("first_fetch", instructionAddress, 32'h0);

    run_iss();
    clear_mon();
    run_until_halt(300, 10);
    check_directed("dir");

    // Restart, then pull reset in the middle of the branch loop.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (25) @(negedge clk);
    check_eq("midrun_in_loop", 32'(dut.regFile.regFile[8] != 32'd0), 32'd1);
    reset = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge clk) reset = 1'b1;
    run_iss();
    clear_mon();
    run_until_halt(300, 10);
    check_directed("rerun");

    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(20, 40);
      @(negedge clk) reset = 1'b0;
      gen_program(n);
      for (int i = 0; i < 64; i++) dmem[i] = $urandom;
      run_iss();
      clear_mon();
      @(negedge clk) reset = 1'b1;
      run_until_halt(3 * n + 40, 12);
      compare_state($sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
